// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with centre sampling, framing-error detection
// and a one-entry valid/ready holding register for the received byte.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       int_clk,
    input  logic       rst,
    input  logic       din,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       green_LED,
    output logic       red_LED
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    // The IDLE->START cycle already spends one clock of the half bit, so the
    // start-bit centre test lands one count early.
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

    state_e        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          red_q, red_d;
    logic          sdin, bit_end, stop_ok, stop_bad;

    assign sdin     = sync_q[1];
    assign bit_end  = cnt_q == BIT_END;
    assign stop_ok  = state_q == STOP && bit_end && sdin;
    assign stop_bad = state_q == STOP && bit_end && !sdin;

    always_ff @(posedge int_clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            red_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            red_q   <= red_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = sdin ? IDLE : START;
            START:   if (cnt_q == HALF_END) state_d = sdin ? IDLE : DATA;
            DATA:    if (bit_end && idx_q == 3'd7) state_d = STOP;
            STOP:    if (bit_end) state_d = sdin ? IDLE : BREAK;
            BREAK:   state_d = sdin ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_d  = {sync_q[0], din};
        cnt_d   = (state_d != state_q || state_q == IDLE || state_q == BREAK || bit_end) ? '0 : cnt_q + 1'b1;
        idx_d   = state_q == START ? 3'd0 : (state_q == DATA && bit_end) ? idx_q + 3'd1 : idx_q;
        shift_d = shift_q;
        if (state_q == DATA && bit_end)
            shift_d[idx_q] = sdin;
        data_d  = stop_ok ? shift_q : data_q;
        valid_d = stop_ok || (valid_q && !rx_ready);
        ovr_d   = stop_ok && valid_q && !rx_ready;
        ferr_d  = stop_bad;
        red_d   = stop_bad || (red_q && !stop_ok);
    end

    always_comb begin
        rx_data   = data_q;
        rx_valid  = valid_q;
        frame_err = ferr_q;
        overrun   = ovr_q;
        green_LED = state_q != IDLE;
        red_LED   = red_q;
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed, table-driven and random frames checked every cycle
// against an event-scheduled model of the receiver's observable behaviour.
module tb_uart_receiver;
    localparam int N = 16;
    localparam int H = N / 2;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_red;
    } vec_t;

    logic       int_clk = 1'b0;
    logic       rst, din, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, green_LED, red_LED;

    int         tests = 0, fails = 0;
    int         cyc = 0;
    int         ev[int];
    logic       exp_valid = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0, exp_red = 1'b0;
    logic [7:0] exp_data = 8'h00;
    logic       chk_en = 1'b0, rnd_rdy = 1'b0;
    int         vld_seen = 0, ferr_seen = 0, ovr_seen = 0;
    int         v0, f0, o0, t0;
    vec_t       vecs[7];
    logic [7:0] rb;
    logic       rok;
    int         gap;

    uart_receiver #(.CLKS_PER_BIT(N)) dut (
        .int_clk(int_clk), .rst(rst), .din(din), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun(overrun), .green_LED(green_LED), .red_LED(red_LED)
    );

    always #5 int_clk = ~int_clk;

    // Model: each sent frame schedules its stop-sample edge; outputs follow one edge later.
    always @(posedge int_clk) begin
        cyc      <= cyc + 1;
        exp_ferr <= 1'b0;
        exp_ovr  <= 1'b0;
        if (rst) begin
            exp_valid <= 1'b0;
            exp_data  <= 8'h00;
            exp_red   <= 1'b0;
        end else if (ev.exists(cyc) && ev[cyc] >= 0) begin
            exp_data  <= 8'(ev[cyc]);
            exp_valid <= 1'b1;
            exp_ovr   <= exp_valid && !rx_ready;
            exp_red   <= 1'b0;
        end else begin
            if (ev.exists(cyc)) begin
                exp_ferr <= 1'b1;
                exp_red  <= 1'b1;
            end
            if (exp_valid && rx_ready)
                exp_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge int_clk);
        if (chk_en) begin
            tests++;
            if ({rx_valid, frame_err, overrun, red_LED} !== {exp_valid, exp_ferr, exp_ovr, exp_red} || rx_data !== exp_data) begin
                fails++;
                $display("FAIL cycle %0d: got v=%b d=%h fe=%b ov=%b red=%b want v=%b d=%h fe=%b ov=%b red=%b",
                         cyc, rx_valid, rx_data, frame_err, overrun, red_LED,
                         exp_valid, exp_data, exp_ferr, exp_ovr, exp_red);
            end
        end
        vld_seen  += int'(rx_valid === 1'b1);
        ferr_seen += int'(frame_err === 1'b1);
        ovr_seen  += int'(overrun === 1'b1);
        @(posedge int_clk);
        #1;
        if (rnd_rdy) rx_ready = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok, input logic hs, input logic chk_green);
        int s0, se;
        logic [9:0] bits;
        s0 = cyc;
        se = s0 + H + 1 + 9 * N;
        ev[se] = stop_ok ? int'(b) : -1;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            din = bits[i];
            for (int j = 0; j < N; j++) begin
                if (hs) rx_ready = (cyc == se);
                tick();
                if (chk_green)
                    check("green_in_frame", 32'(green_LED), 32'(cyc - 1 >= s0 + 2 && cyc - 1 < se));
            end
        end
        if (hs) rx_ready = 1'b0;
    endtask

    task automatic handshake();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};

        rst = 1'b1; din = 1'b0; rx_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0; din = 1'b1;
        check("rst_valid", 32'(rx_valid), 32'(0));
        check("rst_data", 32'(rx_data), 32'(0));
        check("rst_ferr", 32'(frame_err), 32'(0));
        check("rst_ovr", 32'(overrun), 32'(0));
        check("rst_green", 32'(green_LED), 32'(0));
        check("rst_red", 32'(red_LED), 32'(0));
        v0 = vld_seen;
        repeat (400) tick();
        check("rst_no_valid", 32'(vld_seen - v0), 32'(0));

        send(8'hA5, 1'b1, 1'b0, 1'b1);
        din = 1'b1;
        tick();
        check("a5_valid", 32'(rx_valid), 32'(1));
        check("a5_data", 32'(rx_data), 32'(8'hA5));
        handshake();
        check("a5_hs_clear", 32'(rx_valid), 32'(0));

        din = 1'b0; t0 = cyc; v0 = vld_seen; f0 = ferr_seen;
        for (int j = 0; j < 30; j++) begin
            if (j == 4) din = 1'b1;
            tick();
            if (cyc - 1 == t0 + 1) check("glitch_green_e1", 32'(green_LED), 32'(0));
            if (cyc - 1 == t0 + 2) check("glitch_green_e2", 32'(green_LED), 32'(1));
            if (cyc - 1 == t0 + H) check("glitch_green_eH", 32'(green_LED), 32'(1));
            if (cyc - 1 == t0 + H + 1) check("glitch_idle", 32'(green_LED), 32'(0));
        end
        check("glitch_no_valid", 32'(vld_seen - v0), 32'(0));
        check("glitch_no_ferr", 32'(ferr_seen - f0), 32'(0));

        f0 = ferr_seen; v0 = vld_seen;
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (100) tick();
        check("brk_green", 32'(green_LED), 32'(1));
        check("brk_red", 32'(red_LED), 32'(1));
        check("brk_valid", 32'(rx_valid), 32'(0));
        check("brk_ferr_once", 32'(ferr_seen - f0), 32'(1));
        check("brk_no_frame", 32'(vld_seen - v0), 32'(0));
        din = 1'b1;
        repeat (N) tick();
        send(8'h81, 1'b1, 1'b0, 1'b1);
        din = 1'b1;
        tick();
        check("brk_81_data", 32'(rx_data), 32'(8'h81));
        check("brk_red_clear", 32'(red_LED), 32'(0));
        handshake();

        o0 = ovr_seen;
        send(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0);
        din = 1'b1;
        tick();
        check("ovr_once", 32'(ovr_seen - o0), 32'(1));
        check("ovr_data", 32'(rx_data), 32'(8'h22));
        check("ovr_valid", 32'(rx_valid), 32'(1));
        handshake();

        o0 = ovr_seen;
        send(8'h3A, 1'b1, 1'b0, 1'b0);
        send(8'h7E, 1'b1, 1'b1, 1'b0);
        din = 1'b1;
        tick();
        check("sim_no_ovr", 32'(ovr_seen - o0), 32'(0));
        check("sim_valid", 32'(rx_valid), 32'(1));
        check("sim_data", 32'(rx_data), 32'(8'h7E));
        handshake();

        for (int r = 0; r < 7; r++) begin
            send(vecs[r].data, vecs[r].stop, 1'b0, vecs[r].stop);
            din = 1'b1;
            repeat (N) tick();
            check("vec_valid", 32'(rx_valid), 32'(vecs[r].exp_valid));
            check("vec_data", 32'(rx_data), 32'(vecs[r].exp_data));
            check("vec_red", 32'(red_LED), 32'(vecs[r].exp_red));
            if (rx_valid) handshake();
        end

        din = 1'b0;
        repeat (40) tick();
        rst = 1'b1; din = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_green", 32'(green_LED), 32'(0));
        check("midrst_valid", 32'(rx_valid), 32'(0));
        check("midrst_data", 32'(rx_data), 32'(0));
        send(8'hC3, 1'b1, 1'b0, 1'b1);
        din = 1'b1;
        tick();
        check("midrst_c3", 32'(rx_data), 32'(8'hC3));
        handshake();

        rnd_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 7) != 0);
            send(rb, rok, 1'b0, 1'b0);
            din = 1'b1;
            gap = rok ? $urandom_range(0, N) : N;
            repeat (gap) tick();
        end
        rnd_rdy = 1'b0;
        rx_ready = 1'b0;
        repeat (3 * N) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
